// File: rtl/uart_arb_pkg.sv
// Shared types and SLIP constants for the UART TX frame arbiter.
package uart_arb_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StHdr,
    StData,
    StEsc2,
    StCsum,
    StEnd
  } state_e;

  localparam logic [7:0] SLIP_END = 8'hC0;
  localparam logic [7:0] SLIP_ESC = 8'hDB;
  localparam logic [7:0] ESC_END  = 8'hDC;
  localparam logic [7:0] ESC_ESC  = 8'hDD;
  localparam logic [3:0] HDR_TAG  = 4'hA;

  function automatic logic is_slip_special(input logic [7:0] b);
    return (b == SLIP_END) || (b == SLIP_ESC);
  endfunction

  // Second byte of the escape pair for a special byte.
  function automatic logic [7:0] slip_code(input logic [7:0] b);
    return (b == SLIP_END) ? ESC_END : ESC_ESC;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first set request searching upward from ptr_i, wrapping.
module rr_arbiter #(
  parameter int unsigned NCH  = 4,
  parameter int unsigned PtrW = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic [NCH-1:0]  req_i,
  input  logic [PtrW-1:0] ptr_i,
  output logic [NCH-1:0]  grant_o,
  output logic [PtrW-1:0] idx_o
);

  logic            found;
  logic [PtrW-1:0] j;

  always_comb begin
    grant_o = '0;
    idx_o   = '0;
    found   = 1'b0;
    j       = '0;
    for (int unsigned k = 0; k < NCH; k++) begin
      j = PtrW'((32'(ptr_i) + k) % NCH);
      if (!found && req_i[j]) begin
        found      = 1'b1;
        grant_o[j] = 1'b1;
        idx_o      = j;
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin framer sharing one TX FIFO write port: header, SLIP-escaped payload, END byte.
// Define UART_TX_ARB_CHECKSUM_EN to append an escaped XOR checksum before END.
module uart_tx_arbiter
  import uart_arb_pkg::*;
#(
  parameter int unsigned NCH       = 4,
  parameter int unsigned MAX_BURST = 16
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic [NCH-1:0]   REQ_VALID,
  input  logic [NCH*8-1:0] REQ_DATA,
  input  logic [NCH-1:0]   REQ_LAST,
  output logic [NCH-1:0]   REQ_READY,
  output logic             FIFO_WREN,
  output logic [7:0]       FIFO_DOUT,
  input  logic             FIFO_FULL,
  output logic [NCH-1:0]   GRANT,
  output logic             BUSY
);

  localparam int unsigned PtrW = (NCH > 1) ? $clog2(NCH) : 1;

  state_e          state_q;
  state_e          esc_next_q;
  logic [PtrW-1:0] rr_ptr_q;
  logic [PtrW-1:0] g_q;
  logic [NCH-1:0]  grant_q;
  logic            busy_q;
  logic [7:0]      cnt_q;
  logic [7:0]      esc_q;
`ifdef UART_TX_ARB_CHECKSUM_EN
  logic [7:0]      csum_q;
`endif

  logic [NCH-1:0]  arb_grant;
  logic [PtrW-1:0] arb_idx;
  logic [7:0]      lane_bytes [NCH];
  logic [7:0]      lane_data;
  logic            lane_valid;
  logic            lane_last;
  logic            accept;
  logic            burst_end;
  logic [8:0]      cnt_inc;
  state_e          after_burst;

  rr_arbiter #(
    .NCH  (NCH),
    .PtrW (PtrW)
  ) u_rr (
    .req_i   (REQ_VALID),
    .ptr_i   (rr_ptr_q),
    .grant_o (arb_grant),
    .idx_o   (arb_idx)
  );

  for (genvar i = 0; i < NCH; i++) begin : g_lane
    assign lane_bytes[i] = REQ_DATA[8*i +: 8];
  end

  assign lane_data  = lane_bytes[g_q];
  assign lane_valid = REQ_VALID[g_q];
  assign lane_last  = REQ_LAST[g_q];
  assign cnt_inc    = {1'b0, cnt_q} + 9'd1;
  assign burst_end  = lane_last || (cnt_inc == 9'(MAX_BURST));

`ifdef UART_TX_ARB_CHECKSUM_EN
  assign after_burst = StCsum;
`else
  assign after_burst = StEnd;
`endif

  assign GRANT = grant_q;
  assign BUSY  = busy_q;

  always_comb begin
    FIFO_WREN = 1'b0;
    FIFO_DOUT = 8'h00;
    REQ_READY = '0;
    accept    = 1'b0;
    unique case (state_q)
      StHdr: begin
        FIFO_WREN = !FIFO_FULL;
        FIFO_DOUT = {HDR_TAG, 4'(g_q)};
      end
      StData: begin
        accept    = lane_valid && !FIFO_FULL;
        REQ_READY = grant_q & {NCH{accept}};
        FIFO_WREN = accept;
        FIFO_DOUT = is_slip_special(lane_data) ? SLIP_ESC : lane_data;
      end
      StEsc2: begin
        FIFO_WREN = !FIFO_FULL;
        FIFO_DOUT = esc_q;
      end
`ifdef UART_TX_ARB_CHECKSUM_EN
      StCsum: begin
        FIFO_WREN = !FIFO_FULL;
        FIFO_DOUT = is_slip_special(csum_q) ? SLIP_ESC : csum_q;
      end
`endif
      StEnd: begin
        FIFO_WREN = !FIFO_FULL;
        FIFO_DOUT = SLIP_END;
      end
      default: ;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q    <= StIdle;
      esc_next_q <= StIdle;
      rr_ptr_q   <= '0;
      g_q        <= '0;
      grant_q    <= '0;
      busy_q     <= 1'b0;
      cnt_q      <= '0;
      esc_q      <= '0;
`ifdef UART_TX_ARB_CHECKSUM_EN
      csum_q     <= '0;
`endif
    end else begin
      unique case (state_q)
        StIdle: begin
          if (|REQ_VALID) begin
            g_q     <= arb_idx;
            grant_q <= arb_grant;
            busy_q  <= 1'b1;
            cnt_q   <= '0;
            state_q <= StHdr;
          end
        end
        StHdr: begin
          if (!FIFO_FULL) begin
`ifdef UART_TX_ARB_CHECKSUM_EN
            csum_q  <= '0;
`endif
            state_q <= StData;
          end
        end
        StData: begin
          if (accept) begin
            cnt_q <= cnt_inc[7:0];
`ifdef UART_TX_ARB_CHECKSUM_EN
            csum_q <= csum_q ^ lane_data;
`endif
            if (is_slip_special(lane_data)) begin
              // Burst-end decision is parked until the second escape byte goes out.
              esc_q      <= slip_code(lane_data);
              esc_next_q <= burst_end ? after_burst : StData;
              state_q    <= StEsc2;
            end else begin
              state_q <= burst_end ? after_burst : StData;
            end
          end
        end
        StEsc2: begin
          if (!FIFO_FULL) state_q <= esc_next_q;
        end
        StCsum: begin
`ifdef UART_TX_ARB_CHECKSUM_EN
          if (!FIFO_FULL) begin
            if (is_slip_special(csum_q)) begin
              esc_q      <= slip_code(csum_q);
              esc_next_q <= StEnd;
              state_q    <= StEsc2;
            end else begin
              state_q <= StEnd;
            end
          end
`else
          state_q <= StIdle;
`endif
        end
        StEnd: begin
          if (!FIFO_FULL) begin
            rr_ptr_q <= (g_q == PtrW'(NCH - 1)) ? '0 : g_q + 1'b1;
            grant_q  <= '0;
            busy_q   <= 1'b0;
            state_q  <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench for uart_tx_arbiter: directed frames plus randomized traffic vs a frame model.
module tb_uart_tx_arbiter;

  localparam int NCH = 4;
  localparam int MB  = 4;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [NCH-1:0]   req_valid = '0;
  logic [NCH-1:0]   req_last = '0;
  logic [NCH*8-1:0] req_data = '0;
  logic             full = 1'b0;
  logic [NCH-1:0]   req_ready;
  logic [NCH-1:0]   grant;
  logic             wren;
  logic [7:0]       dout;
  logic             busy;

  int checks = 0;
  int errors = 0;

  logic [8:0] chq [NCH][$];
  logic [8:0] mq  [NCH][$];
  logic [7:0] got[$];
  logic [7:0] exp_q[$];

  int tcyc, grant_cnt, ready_pulses, v_full, v_ready, v_stall, v_grant;
  int stall_from, stall_len;
  bit bubble_en, rand_full_en;
  logic [NCH-1:0] watch_grant, allow_mask;

  always #5 clk = ~clk;

  uart_tx_arbiter #(
    .NCH       (NCH),
    .MAX_BURST (MB)
  ) dut (
    .CLK       (clk),
    .RESET     (rst),
    .REQ_VALID (req_valid),
    .REQ_DATA  (req_data),
    .REQ_LAST  (req_last),
    .REQ_READY (req_ready),
    .FIFO_WREN (wren),
    .FIFO_DOUT (dout),
    .FIFO_FULL (full),
    .GRANT     (grant),
    .BUSY      (busy)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  function automatic bit all_empty();
    for (int i = 0; i < NCH; i++) if (chq[i].size() != 0) return 1'b0;
    return 1'b1;
  endfunction

  task automatic push(input int ch, input logic [7:0] b, input logic last);
    chq[ch].push_back({last, b});
    mq[ch].push_back({last, b});
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst       = 1'b1;
    req_valid = '0;
    req_last  = '0;
    req_data  = '0;
    full      = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
  endtask

  task automatic prep();
    do_reset();
    for (int i = 0; i < NCH; i++) begin
      chq[i].delete();
      mq[i].delete();
    end
    got.delete();
    exp_q.delete();
    tcyc = 0; grant_cnt = 0; ready_pulses = 0;
    v_full = 0; v_ready = 0; v_stall = 0; v_grant = 0;
    stall_from = 32'h3fff_ffff; stall_len = 0;
    bubble_en = 1'b0; rand_full_en = 1'b0;
    watch_grant = '1; allow_mask = '1;
  endtask

  // One clock: drive at the falling edge, sample 1 time unit later, commit at the rising edge.
  task automatic cycle();
    bit in_stall;
    @(negedge clk);
    for (int i = 0; i < NCH; i++) begin
      if (chq[i].size() > 0 && !(bubble_en && grant[i] && $urandom_range(0, 2) == 0)) begin
        req_valid[i]       = 1'b1;
        req_data[8*i +: 8] = chq[i][0][7:0];
        req_last[i]        = chq[i][0][8];
      end else begin
        req_valid[i]       = 1'b0;
        req_data[8*i +: 8] = 8'h00;
        req_last[i]        = 1'b0;
      end
    end
    in_stall = (tcyc >= stall_from) && (tcyc < stall_from + stall_len);
    full = in_stall || (rand_full_en && $urandom_range(0, 3) == 0);
    #1;
    if (wren) got.push_back(dout);
    if (wren && full) v_full++;
    if ((req_ready & ~grant) != 0 || (req_ready & ~req_valid) != 0 || $countones(req_ready) > 1)
      v_ready++;
    if (in_stall && (wren || req_ready != 0)) v_stall++;
    if ((grant & ~allow_mask) != 0) v_grant++;
    if (grant == watch_grant) grant_cnt++;
    if (req_ready != 0) ready_pulses++;
    for (int i = 0; i < NCH; i++) if (req_ready[i]) void'(chq[i].pop_front());
    tcyc++;
  endtask

  task automatic run_done(input string tag, input int budget);
    int n;
    bit done;
    n = 0;
    done = 1'b0;
    do begin
      cycle();
      n++;
      done = all_empty() && !busy;
    end while (!done && n < budget);
    chk({tag, "_done"}, 32'(done), 32'd1);
  endtask

  task automatic cmp_stream(input string tag);
    int n;
    chk({tag, "_len"}, got.size(), exp_q.size());
    n = (got.size() < exp_q.size()) ? got.size() : exp_q.size();
    for (int k = 0; k < n; k++) chk($sformatf("%s_b%0d", tag, k), got[k], exp_q[k]);
  endtask

  task automatic end_checks(input string tag);
    chk({tag, "_wr_when_full"}, v_full, 0);
    chk({tag, "_ready_rule"}, v_ready, 0);
    chk({tag, "_grant_mask"}, v_grant, 0);
  endtask

  function automatic void push_esc(input logic [7:0] b);
    if (b == 8'hC0) begin
      exp_q.push_back(8'hDB); exp_q.push_back(8'hDC);
    end else if (b == 8'hDB) begin
      exp_q.push_back(8'hDB); exp_q.push_back(8'hDD);
    end else begin
      exp_q.push_back(b);
    end
  endfunction

  // Frame-level model: whole messages queued per channel, round-robin over non-empty queues.
  task automatic build_model();
    int ptr, sel, n;
    bit fin;
    logic [8:0] it;
    logic [7:0] cs;
    ptr = 0;
    exp_q.delete();
    forever begin
      sel = -1;
      for (int k = 0; k < NCH; k++)
        if (sel < 0 && mq[(ptr + k) % NCH].size() > 0) sel = (ptr + k) % NCH;
      if (sel < 0) break;
      exp_q.push_back({4'hA, 4'(sel)});
      n = 0; cs = 8'h00; fin = 1'b0;
      while (!fin) begin
        it = mq[sel].pop_front();
        push_esc(it[7:0]);
        cs = cs ^ it[7:0];
        n++;
        fin = it[8] || (n == MB);
      end
`ifdef UART_TX_ARB_CHECKSUM_EN
      push_esc(cs);
`endif
      exp_q.push_back(8'hC0);
      ptr = (sel + 1) % NCH;
    end
  endtask

  initial begin
    int c0s;
    prep();
    chk("rst_grant", grant, 0);
    chk("rst_busy", busy, 0);
    chk("rst_wren", wren, 0);
    chk("rst_ready", req_ready, 0);

    // Single requester
    prep();
    watch_grant = 4'b0010; allow_mask = 4'b0010;
    push(1, 8'h11, 1'b0); push(1, 8'h22, 1'b1);
    run_done("single", 40);
`ifdef UART_TX_ARB_CHECKSUM_EN
    exp_q = '{8'hA1, 8'h11, 8'h22, 8'h33, 8'hC0};
    chk("single_grant_cycles", grant_cnt, 5);
`else
    exp_q = '{8'hA1, 8'h11, 8'h22, 8'hC0};
    chk("single_grant_cycles", grant_cnt, 4);
`endif
    cmp_stream("single");
    end_checks("single");

    // Escaping
    prep();
    push(0, 8'hC0, 1'b0); push(0, 8'hDB, 1'b1);
    run_done("esc", 40);
`ifdef UART_TX_ARB_CHECKSUM_EN
    exp_q = '{8'hA0, 8'hDB, 8'hDC, 8'hDB, 8'hDD, 8'h1B, 8'hC0};
`else
    exp_q = '{8'hA0, 8'hDB, 8'hDC, 8'hDB, 8'hDD, 8'hC0};
`endif
    cmp_stream("esc");
    chk("esc_ready_pulses", ready_pulses, 2);
    end_checks("esc");

    // Round-robin between ch0 and ch2
    prep();
    allow_mask = 4'b0101;
    for (int k = 0; k < 3; k++) begin
      push(0, 8'(8'h10 + k), 1'b1);
      push(2, 8'(8'h30 + k), 1'b1);
    end
    run_done("rr", 100);
    for (int k = 0; k < 3; k++) begin
      for (int c = 0; c <= 2; c += 2) begin
        exp_q.push_back({4'hA, 4'(c)});
        exp_q.push_back(8'(8'h10 * (c + 1) + k));
`ifdef UART_TX_ARB_CHECKSUM_EN
        exp_q.push_back(8'(8'h10 * (c + 1) + k));
`endif
        exp_q.push_back(8'hC0);
      end
    end
    cmp_stream("rr");
    end_checks("rr");

    // MAX_BURST split
    prep();
    for (int k = 1; k <= 6; k++) push(3, 8'(k), k == 6);
    run_done("maxb", 60);
`ifdef UART_TX_ARB_CHECKSUM_EN
    exp_q = '{8'hA3, 8'h01, 8'h02, 8'h03, 8'h04, 8'h04, 8'hC0, 8'hA3, 8'h05, 8'h06, 8'h03, 8'hC0};
`else
    exp_q = '{8'hA3, 8'h01, 8'h02, 8'h03, 8'h04, 8'hC0, 8'hA3, 8'h05, 8'h06, 8'hC0};
`endif
    cmp_stream("maxb");
    end_checks("maxb");

    // FIFO_FULL stall for 5 cycles right after the first payload byte
    prep();
    stall_from = 3; stall_len = 5;
    push(1, 8'h31, 1'b0); push(1, 8'h32, 1'b0); push(1, 8'h33, 1'b1);
    run_done("stall", 60);
`ifdef UART_TX_ARB_CHECKSUM_EN
    exp_q = '{8'hA1, 8'h31, 8'h32, 8'h33, 8'h30, 8'hC0};
`else
    exp_q = '{8'hA1, 8'h31, 8'h32, 8'h33, 8'hC0};
`endif
    cmp_stream("stall");
    chk("stall_quiet", v_stall, 0);
    end_checks("stall");

    // Reset in the middle of a payload
    prep();
    push(2, 8'h41, 1'b0); push(2, 8'h42, 1'b0); push(2, 8'h43, 1'b1);
    repeat (3) cycle();
    rst = 1'b1;
    cycle();
    chk("midrst_grant", grant, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_wren", wren, 0);
    for (int i = 0; i < NCH; i++) chq[i].delete();
    req_valid = '0;
    rst = 1'b0;
    repeat (3) cycle();
    c0s = 0;
    foreach (got[k]) if (got[k] == 8'hC0) c0s++;
    chk("midrst_no_end", c0s, 0);
    chk("midrst_len", got.size(), 2);

    // Randomized traffic with bubbles and random FIFO_FULL
    for (int r = 0; r < 4; r++) begin
      prep();
      bubble_en = 1'b1; rand_full_en = 1'b1;
      for (int ch = 0; ch < NCH; ch++) begin
        int nm, len, sel;
        logic [7:0] b;
        nm = $urandom_range(0, 3);
        for (int m = 0; m < nm; m++) begin
          len = $urandom_range(1, 7);
          for (int k = 0; k < len; k++) begin
            sel = $urandom_range(0, 3);
            b = (sel == 0) ? 8'hC0 : (sel == 1) ? 8'hDB : 8'($urandom_range(0, 255));
            push(ch, b, k == len - 1);
          end
        end
      end
      build_model();
      run_done($sformatf("rnd%0d", r), 4000);
      cmp_stream($sformatf("rnd%0d", r));
      end_checks($sformatf("rnd%0d", r));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
